// File: rtl/ram_master_pkg.sv
// Shared encodings for the byte-RAM requester: access sizes, FSM states, lane width.
// Also holds the small decode helpers used by ram_word_master.
package ram_master_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    // Index of the final byte lane; size 3 behaves as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            SZ_BYTE: last_idx = 2'd0;
            SZ_HALF: last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                     ((size != SZ_BYTE) && (size != SZ_HALF) && (addr_lo != 2'd0));
    endfunction

endpackage

// File: rtl/ram_word_master.sv
// Splits one 8/16/32-bit load/store into little-endian byte cycles on a byte-wide RAM.
// Latency: accept, n RAM cycles, then response (n+2 min); misaligned with ALIGN_CHECK_EN: straight to response.
// Backpressure: req_ready low while busy; response held in RESP until rsp_ready, no RAM activity meanwhile.
module ram_word_master
    import ram_master_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         acc_q, acc_d;
`ifdef ALIGN_CHECK_EN
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        acc_d     = acc_q;
`ifdef ALIGN_CHECK_EN
        err_d     = err_q;
`endif
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        ram_ena   = 1'b0;
        ram_wena  = 1'b0;
        ram_addr  = '0;
        ram_wdata = 8'h0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    last_d  = last_idx(req_size);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    acc_d   = 32'h0;
                    state_d = XFER;
`ifdef ALIGN_CHECK_EN
                    err_d   = 1'b0;
                    if (misaligned(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
            end
            XFER: begin
                ram_ena   = 1'b1;
                ram_wena  = we_q;
                // Adder width equals the RAM address width, so the top wraps to 0.
                ram_addr  = addr_q + ADDR_W'(cnt_q);
                ram_wdata = wdata_q[{cnt_q, 3'b000} +: BYTE_W];
                if (!we_q) begin
                    acc_d[{cnt_q, 3'b000} +: BYTE_W] = ram_rdata;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_q) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = acc_q;
`ifdef ALIGN_CHECK_EN
                rsp_err   = err_q;
`endif
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            last_q  <= 2'd0;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            acc_q   <= 32'h0;
`ifdef ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
`ifdef ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule
